// File: rtl/mem_burst_rd.sv
// -----------------------------------------------------------------------------
// mem_burst_rd
//
// Burst reader for the narrow-word shared memory (port B read side). It takes
// a wide-word read request and issues 2^MULTLOG sequential narrow reads per
// wide word on a RAM port with 1-cycle read latency. The narrow results are
// packed into DWB-wide words and delivered on a valid/ready stream through a
// 2-entry output buffer.
//
// Ports
//   clk_b          clock
//   rst_b_n        asynchronous active-low reset
//   i_req_valid    request valid
//   o_req_ready    request accepted when valid & ready
//   i_req_addr     start wide-word address
//   i_req_len      burst length minus 1, in wide words
//   o_ram_rd_en    narrow read strobe
//   o_ram_addr     narrow read address {wide_addr, slice}
//   i_ram_data     narrow read data, valid the cycle after o_ram_rd_en
//   o_data_valid   packed word valid
//   i_data_ready   consumer ready
//   o_data         packed wide word
//   o_data_last    final word of the burst
//
// Build option
//   MEM_BURST_RD_MSB_FIRST_EN  defined: lowest narrow address lands in the
//                              MSBs of the packed word. Undefined: LSBs.
//
// State | Meaning
// ------+----------------------------------------------------------------------
// IDLE  | ready for a request
// READ  | one narrow read per cycle
// STALL | output buffer plus words in assembly leave no room; no reads
// LAST  | final read issued; wait one cycle for its capture
// -----------------------------------------------------------------------------
module mem_burst_rd #(
    parameter int DWA     = 16,
    parameter int MULTLOG = 1,
    parameter int AWB     = 4
) (
    input  logic                           clk_b,
    input  logic                           rst_b_n,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [AWB-1:0]                 i_req_addr,
    input  logic [3:0]                     i_req_len,
    output logic                           o_ram_rd_en,
    output logic [AWB+MULTLOG-1:0]         o_ram_addr,
    input  logic [DWA-1:0]                 i_ram_data,
    output logic                           o_data_valid,
    input  logic                           i_data_ready,
    output logic [DWA*(1<<MULTLOG)-1:0]    o_data,
    output logic                           o_data_last
);

    localparam int MULTNUM = 1 << MULTLOG;
    localparam int AWA     = AWB + MULTLOG;
    localparam int DWB     = DWA * MULTNUM;
    localparam int SW      = (MULTLOG > 0) ? MULTLOG : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_STALL = 2'd2,
        S_LAST  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              alive_q;
    logic [AWB-1:0]    wide_addr_q, wide_addr_d;
    logic [SW-1:0]     slice_q, slice_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        word_cnt_q, word_cnt_d;
    logic [1:0]        in_flight_q, in_flight_d;

    logic              cap_en_q;
    logic              cap_push_q;
    logic              cap_last_q;
    logic [SW-1:0]     cap_slice_q;
    logic [DWB-1:0]    asm_q, asm_d;

    logic [DWB:0]      fifo_mem_q [2];
    logic              fifo_wr_q;
    logic              fifo_rd_q;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic              rd_en;
    logic              last_slice;
    logic              final_word;
    logic              credit_ok;
    logic              start_word;
    logic              push;
    logic              pop;

    assign rd_en      = (state_q == S_READ);
    assign last_slice = (slice_q == SW'(MULTNUM - 1));
    assign final_word = (word_cnt_q == len_q);
    // Words in the buffer plus words whose reads have started but are not yet
    // pushed. Registered state only, so consumer ready never reaches rd_en.
    assign credit_ok  = ((3'(fifo_cnt_q) + 3'(in_flight_q)) < 3'd2);
    assign push       = cap_push_q;
    assign pop        = o_data_valid & i_data_ready;

    always_comb begin
        state_d     = state_q;
        wide_addr_d = wide_addr_q;
        slice_d     = slice_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        start_word  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid && alive_q) begin
                    wide_addr_d = i_req_addr;
                    len_d       = i_req_len;
                    slice_d     = '0;
                    word_cnt_d  = '0;
                    // A full buffer left over from the previous burst must
                    // drain before the first word of the new one may start.
                    if (credit_ok) begin
                        state_d    = S_READ;
                        start_word = 1'b1;
                    end else begin
                        state_d    = S_STALL;
                    end
                end
            end
            S_READ: begin
                if (last_slice) begin
                    slice_d     = '0;
                    wide_addr_d = wide_addr_q + AWB'(1);
                    word_cnt_d  = word_cnt_q + 4'd1;
                    if (final_word) begin
                        state_d = S_LAST;
                    end else if (credit_ok) begin
                        start_word = 1'b1;
                    end else begin
                        state_d = S_STALL;
                    end
                end else begin
                    slice_d = slice_q + SW'(1);
                end
            end
            S_STALL: begin
                if (credit_ok) begin
                    state_d    = S_READ;
                    start_word = 1'b1;
                end
            end
            S_LAST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_flight_d = in_flight_q + 2'(start_word) - 2'(push);
    assign fifo_cnt_d  = fifo_cnt_q + 2'(push) - 2'(pop);

    // The final slice is merged straight from the RAM so the word is pushed
    // in the same cycle its last narrow read returns.
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < MULTNUM; k++) begin
            if (cap_en_q && (cap_slice_q == SW'(k))) begin
`ifdef MEM_BURST_RD_MSB_FIRST_EN
                asm_d[(MULTNUM-1-k)*DWA +: DWA] = i_ram_data;
`else
                asm_d[k*DWA +: DWA] = i_ram_data;
`endif
            end
        end
    end

    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            state_q     <= S_IDLE;
            alive_q     <= 1'b0;
            wide_addr_q <= '0;
            slice_q     <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            in_flight_q <= '0;
            cap_en_q    <= 1'b0;
            cap_push_q  <= 1'b0;
            cap_last_q  <= 1'b0;
            cap_slice_q <= '0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            alive_q     <= 1'b1;
            wide_addr_q <= wide_addr_d;
            slice_q     <= slice_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            in_flight_q <= in_flight_d;
            cap_en_q    <= rd_en;
            cap_push_q  <= rd_en & last_slice;
            cap_last_q  <= final_word;
            cap_slice_q <= slice_q;
            asm_q       <= asm_d;
        end
    end

    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem_q[i] <= '0;
            end
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[fifo_wr_q] <= {cap_last_q, asm_d};
                fifo_wr_q             <= ~fifo_wr_q;
            end
            if (pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Ready is held low through reset and rises one edge after release.
    assign o_req_ready  = (state_q == S_IDLE) && alive_q;
    assign o_ram_rd_en  = rd_en;
    assign o_ram_addr   = (AWA'(wide_addr_q) << MULTLOG) | AWA'(slice_q);
    assign o_data_valid = (fifo_cnt_q != 2'd0);
    assign {o_data_last, o_data} = fifo_mem_q[fifo_rd_q];

endmodule

// File: tb/tb_mem_burst_rd.sv
module tb_mem_burst_rd;

    localparam int DWA     = 16;
    localparam int MULTLOG = 1;
    localparam int AWB     = 4;
    localparam int AWA     = AWB + MULTLOG;
    localparam int DWB     = DWA * (1 << MULTLOG);

    logic              clk_b = 1'b0;
    logic              rst_b_n;
    logic              i_req_valid;
    logic              o_req_ready;
    logic [AWB-1:0]    i_req_addr;
    logic [3:0]        i_req_len;
    logic              o_ram_rd_en;
    logic [AWA-1:0]    o_ram_addr;
    logic [DWA-1:0]    i_ram_data;
    logic              o_data_valid;
    logic              i_data_ready;
    logic [DWB-1:0]    o_data;
    logic              o_data_last;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                rd_cnt  = 0;
    logic [DWB:0]      exp_q[$];
    logic [AWA-1:0]    addr_q[$];

    mem_burst_rd #(.DWA(DWA), .MULTLOG(MULTLOG), .AWB(AWB)) dut (
        .clk_b        (clk_b),
        .rst_b_n      (rst_b_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_len    (i_req_len),
        .o_ram_rd_en  (o_ram_rd_en),
        .o_ram_addr   (o_ram_addr),
        .i_ram_data   (i_ram_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_data       (o_data),
        .o_data_last  (o_data_last)
    );

    always #5 clk_b = ~clk_b;

    always @(posedge clk_b) begin
        if (o_ram_rd_en) i_ram_data <= 16'hA000 | 16'(o_ram_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DWB:0] exp_word(input logic [AWB-1:0] wa, input logic last);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'hA000 | {11'd0, wa, 1'b0};
        hi = lo | 16'h0001;
`ifdef MEM_BURST_RD_MSB_FIRST_EN
        return {last, lo, hi};
`else
        return {last, hi, lo};
`endif
    endfunction

    always @(negedge clk_b) begin
        if (rst_b_n && o_ram_rd_en) begin
            rd_cnt++;
            if (addr_q.size() == 0) chk("rd_unexpected", 64'(o_ram_addr), 64'hFFFF);
            else chk("rd_addr", 64'(o_ram_addr), 64'(addr_q.pop_front()));
        end
    end

    always @(negedge clk_b) begin
        if (rst_b_n && o_data_valid && i_data_ready) begin
            if (exp_q.size() == 0) chk("data_unexpected", 64'({o_data_last, o_data}), 64'hFFFF_FFFF_FFFF);
            else chk("data", 64'({o_data_last, o_data}), 64'(exp_q.pop_front()));
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input logic [AWB-1:0] addr, input logic [3:0] len);
        logic rdy;
        logic ok;
        logic [AWB-1:0] wa;
        for (int w = 0; w <= int'(len); w++) begin
            wa = addr + AWB'(w);
            addr_q.push_back({wa, 1'b0});
            addr_q.push_back({wa, 1'b1});
            exp_q.push_back(exp_word(wa, w == int'(len)));
        end
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_len   = len;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk_b);
            rdy = o_req_ready;
            @(posedge clk_b);
            ok = rdy;
        end
        #1;
        i_req_valid = 1'b0;
        if (!ok) chk("req_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain(input logic rand_ready);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk_b);
            #1;
            if (rand_ready) i_data_ready = 1'($urandom_range(0, 1));
            else i_data_ready = 1'b1;
            done = (exp_q.size() == 0) && (addr_q.size() == 0) && !o_data_valid;
        end
        i_data_ready = 1'b1;
        if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_b_n      = 1'b0;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        i_req_len    = '0;
        i_data_ready = 1'b1;
        #1;
        chk("rst_outputs", 64'({o_req_ready, o_ram_rd_en, o_ram_addr, o_data_valid, o_data, o_data_last}), 64'd0);
        repeat (3) @(posedge clk_b);
        @(negedge clk_b);
        rst_b_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(o_req_ready), 64'd0);
        @(posedge clk_b);
        #1;
        chk("ready_after_release", 64'(o_req_ready), 64'd1);

        // single word, timing from the accepting edge T
        do_req(4'd3, 4'd0);
        @(negedge clk_b);
        chk("sw_t1_rd", 64'({o_ram_rd_en, o_ram_addr}), 64'({1'b1, 5'd6}));
        chk("sw_t1_ready", 64'(o_req_ready), 64'd0);
        @(negedge clk_b);
        chk("sw_t2_rd", 64'({o_ram_rd_en, o_ram_addr}), 64'({1'b1, 5'd7}));
        @(negedge clk_b);
        chk("sw_t3_idle", 64'({o_ram_rd_en, o_data_valid}), 64'd0);
        @(negedge clk_b);
`ifdef MEM_BURST_RD_MSB_FIRST_EN
        chk("sw_t4_word", 64'({o_data_valid, o_data_last, o_data}), 64'({2'b11, 32'hA006_A007}));
`else
        chk("sw_t4_word", 64'({o_data_valid, o_data_last, o_data}), 64'({2'b11, 32'hA007_A006}));
`endif
        drain(1'b0);

        // wrapping burst, four reads back to back
        @(posedge clk_b);
        #1;
        do_req(4'd15, 4'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_b);
            chk("wrap_b2b", 64'(o_ram_rd_en), 64'd1);
        end
        drain(1'b0);

        // backpressure: two words buffered, then reads stall
        @(posedge clk_b);
        #1;
        i_data_ready = 1'b0;
        rd_cnt = 0;
        do_req(4'd0, 4'd3);
        repeat (12) @(negedge clk_b);
        chk("bp_reads", 64'(rd_cnt), 64'd4);
        chk("bp_stalled", 64'({o_ram_rd_en, o_data_valid, o_req_ready}), 64'b010);
        chk("bp_pending", 64'(exp_q.size()), 64'd4);
        @(posedge clk_b);
        #1;
        i_data_ready = 1'b1;
        drain(1'b0);
        chk("bp_reads_total", 64'(rd_cnt), 64'd8);

        // reset in the middle of a long burst
        @(posedge clk_b);
        #1;
        do_req(4'd5, 4'd7);
        repeat (3) @(posedge clk_b);
        #3;
        rst_b_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1;
        chk("midrst_outputs", 64'({o_req_ready, o_ram_rd_en, o_ram_addr, o_data_valid, o_data, o_data_last}), 64'd0);
        repeat (2) @(posedge clk_b);
        @(negedge clk_b);
        rst_b_n = 1'b1;
        @(posedge clk_b);
        #1;
        chk("midrst_ready", 64'(o_req_ready), 64'd1);
        chk("midrst_valid", 64'(o_data_valid), 64'd0);
        do_req(4'd9, 4'd0);
        @(negedge clk_b);
        chk("midrst_first_addr", 64'({o_ram_rd_en, o_ram_addr}), 64'({1'b1, 5'd18}));
        drain(1'b0);

        // random bursts with random consumer readiness
        for (int b = 0; b < 4; b++) begin
            @(posedge clk_b);
            #1;
            do_req(AWB'($urandom_range(0, 15)), 4'($urandom_range(0, 5)));
            drain(1'b1);
        end
        chk("final_empty", 64'({exp_q.size() == 0, addr_q.size() == 0}), 64'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
